sync_fifo: RTL and testbench

SYNC_FIFO -- requirements
Module: sync_fifo

---
 rtl/sync_fifo_if.sv | 34 +++
 rtl/sync_fifo.sv | 105 ++++++++++
 tb/tb_sync_fifo.sv | 142 ++++++++++++++
 3 files changed

// File: rtl/sync_fifo_if.sv
// Handshake bundle for sync_fifo: producer-side write channel, consumer-side read channel,
// and the optional occupancy report compiled in by SYNC_FIFO_LEVEL_EN.
interface sync_fifo_if #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) ();
  logic [WIDTH-1:0] in0;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] out;
  logic             out_valid;
  logic             out_ready;
`ifdef SYNC_FIFO_LEVEL_EN
  logic [$clog2(DEPTH):0] level;
`endif

  // Environment side: produces write words and consumes read words.
  modport master (
    output in0, in_valid, out_ready,
    input  in_ready, out, out_valid
`ifdef SYNC_FIFO_LEVEL_EN
    , input level
`endif
  );

  // FIFO side.
  modport slave (
    input  in0, in_valid, out_ready,
    output in_ready, out, out_valid
`ifdef SYNC_FIFO_LEVEL_EN
    , output level
`endif
  );
endinterface

// File: rtl/sync_fifo.sv
// First-word-fall-through synchronous FIFO with fully registered flags and head data.
// Optional registered occupancy port `level` is compiled in by SYNC_FIFO_LEVEL_EN.
module sync_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic       clock,
  input  logic       reset,
  sync_fifo_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [AW-1:0]    wr_ptr_r;
  logic [AW-1:0]    rd_ptr_r;
  logic [AW:0]      count_r;
  logic             in_ready_r;
  logic             out_valid_r;
  logic [WIDTH-1:0] out_r;

  logic             wr_en_s;
  logic             rd_en_s;
  logic [AW-1:0]    wr_ptr_nxt_s;
  logic [AW-1:0]    rd_ptr_nxt_s;
  logic [AW:0]      count_nxt_s;
  logic [WIDTH-1:0] out_nxt_s;

  // Pointers wrap naturally because DEPTH is a power of two.
  function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
    return p + AW'(1);
  endfunction

  // Next-state computation for handshakes, pointers, occupancy and the next head word.
  always_comb begin
    wr_en_s      = bus.in_valid & in_ready_r;
    rd_en_s      = bus.out_ready & out_valid_r;
    wr_ptr_nxt_s = wr_ptr_r;
    rd_ptr_nxt_s = rd_ptr_r;
    count_nxt_s  = count_r;
    out_nxt_s    = '0;

    if (wr_en_s) begin
      wr_ptr_nxt_s = ptr_inc(wr_ptr_r);
    end else begin
      wr_ptr_nxt_s = wr_ptr_r;
    end

    if (rd_en_s) begin
      rd_ptr_nxt_s = ptr_inc(rd_ptr_r);
    end else begin
      rd_ptr_nxt_s = rd_ptr_r;
    end

    case ({wr_en_s, rd_en_s})
      2'b10:   count_nxt_s = count_r + (AW+1)'(1);
      2'b01:   count_nxt_s = count_r - (AW+1)'(1);
      default: count_nxt_s = count_r;
    endcase

    // The new head is the incoming word when it lands exactly where the read pointer will point.
    if (wr_en_s && (wr_ptr_r == rd_ptr_nxt_s)) begin
      out_nxt_s = bus.in0;
    end else begin
      out_nxt_s = mem_r[rd_ptr_nxt_s];
    end
  end

  // Storage array; cleared on reset so the head reads back as zero.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= '0;
      end
    end else if (wr_en_s) begin
      mem_r[wr_ptr_r] <= bus.in0;
    end
  end

  // Pointers, occupancy and registered output flags/data.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr_r    <= '0;
      rd_ptr_r    <= '0;
      count_r     <= '0;
      in_ready_r  <= 1'b1;
      out_valid_r <= 1'b0;
      out_r       <= '0;
    end else begin
      wr_ptr_r    <= wr_ptr_nxt_s;
      rd_ptr_r    <= rd_ptr_nxt_s;
      count_r     <= count_nxt_s;
      in_ready_r  <= (count_nxt_s < FULL_CNT);
      out_valid_r <= (count_nxt_s != (AW+1)'(0));
      out_r       <= out_nxt_s;
    end
  end

  assign bus.in_ready  = in_ready_r;
  assign bus.out_valid = out_valid_r;
  assign bus.out       = out_r;
`ifdef SYNC_FIFO_LEVEL_EN
  assign bus.level     = count_r;
`endif
endmodule

// File: tb/tb_sync_fifo.sv
// Directed plus short random test of sync_fifo against a scoreboard queue and occupancy model.
module tb_sync_fifo;
  localparam int WIDTH = 32;
  localparam int DEPTH = 4;

  logic clock = 1'b0;
  logic reset = 1'b1;
  int   checks = 0;
  int   errors = 0;
  int   model_count = 0;
  logic [WIDTH-1:0] sb[$];

  sync_fifo_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) bus ();

  sync_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Compare all outputs against the model's empty state.
  task automatic check_empty(input string tag);
    check({tag, "_out_valid"}, 32'(bus.out_valid), 32'd0);
    check({tag, "_in_ready"}, 32'(bus.in_ready), 32'd1);
    check({tag, "_out"}, bus.out, 32'd0);
`ifdef SYNC_FIFO_LEVEL_EN
    check({tag, "_level"}, 32'(bus.level), 32'd0);
`endif
  endtask

  // One clock cycle: called at a falling edge, checks outputs, drives inputs, updates model.
  task automatic cyc(input logic iv, input logic [31:0] d, input logic ordy);
    logic wr, rd;
    bus.in_valid  = iv;
    bus.in0       = d;
    bus.out_ready = ordy;
    wr = iv && (model_count < DEPTH);
    rd = ordy && (model_count > 0);
    check("out_valid", 32'(bus.out_valid), 32'(model_count > 0));
    check("in_ready", 32'(bus.in_ready), 32'(model_count < DEPTH));
`ifdef SYNC_FIFO_LEVEL_EN
    check("level", 32'(bus.level), 32'(model_count));
`endif
    if (model_count > 0) begin
      check(rd ? "read_data" : "head_hold", bus.out, sb[0]);
    end
    @(posedge clock);
    #1;
    if (rd) begin
      void'(sb.pop_front());
      model_count--;
    end
    if (wr) begin
      sb.push_back(d);
      model_count++;
    end
    @(negedge clock);
  endtask

  initial begin
    bus.in_valid  = 1'b0;
    bus.in0       = '0;
    bus.out_ready = 1'b0;

    // Reset state.
    #12;
    check_empty("reset");
    @(negedge clock);
    reset = 1'b0;

    // Single word, held for three cycles, then read out.
    cyc(1'b1, 32'hA5A5A5A5, 1'b0);
    cyc(1'b0, 32'h0, 1'b0);
    cyc(1'b0, 32'h0, 1'b0);
    cyc(1'b0, 32'h0, 1'b0);
    cyc(1'b0, 32'h0, 1'b1);
    cyc(1'b0, 32'h0, 1'b0);

    // Fill to full, ignored fifth write, drain in order.
    for (int i = 1; i <= 4; i++) cyc(1'b1, 32'(i), 1'b0);
    cyc(1'b1, 32'd5, 1'b0);
    for (int i = 0; i < 4; i++) cyc(1'b0, 32'h0, 1'b1);
    cyc(1'b0, 32'h0, 1'b1);

    // Full with simultaneous write and read: read only.
    for (int i = 0; i < 4; i++) cyc(1'b1, 32'h20 + 32'(i), 1'b0);
    cyc(1'b1, 32'h99, 1'b1);
    cyc(1'b0, 32'h0, 1'b0);

    // Steady state at level 2 with concurrent traffic across several pointer wraps.
    cyc(1'b0, 32'h0, 1'b1);
    for (int i = 0; i < 10; i++) cyc(1'b1, 32'h10 + 32'(i), 1'b1);
    cyc(1'b0, 32'h0, 1'b0);
    for (int i = 0; i < 3; i++) cyc(1'b0, 32'h0, 1'b1);

    // Empty FIFO: write plus out_ready is a write only.
    cyc(1'b1, 32'h5555_0001, 1'b1);
    cyc(1'b0, 32'h0, 1'b0);

    // Asynchronous reset mid-burst at level 3.
    cyc(1'b1, 32'h31, 1'b0);
    cyc(1'b1, 32'h32, 1'b0);
    cyc(1'b0, 32'h0, 1'b0);
    bus.in_valid  = 1'b1;
    bus.in0       = 32'hDEAD_BEEF;
    bus.out_ready = 1'b1;
    #2;
    reset = 1'b1;
    #1;
    check_empty("async_reset");
    @(posedge clock);
    #1;
    check_empty("reset_held_edge");
    @(negedge clock);
    reset = 1'b0;
    sb.delete();
    model_count = 0;
    cyc(1'b1, 32'h77, 1'b0);
    cyc(1'b0, 32'h0, 1'b0);
    cyc(1'b0, 32'h0, 1'b1);

    // Random traffic, then drain.
    for (int i = 0; i < 60; i++) begin
      cyc(1'($urandom_range(0, 1)), $urandom, 1'($urandom_range(0, 1)));
    end
    for (int i = 0; i < 6; i++) cyc(1'b0, 32'h0, 1'b1);
    check("final_drained", 32'(bus.out_valid), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
